param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, >=4.
REQ-003 Parameter AF_THRESH, default DEPTH-2, almost_full asserts when count >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 2, almost_empty asserts when count <= AE_THRESH.
REQ-005 Parameter FWFT, default 0: 0 = registered read (1-cycle latency), 1 = first-word-fall-through.
REQ-006 Derived PTR_WIDTH = clog2(DEPTH); count width is PTR_WIDTH+1.
REQ-007 clk  input  1  single clock; all state changes on rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 clear  input  1  synchronous flush, active-high.
REQ-010 wr_en  input  1  write request.
REQ-011 wdata  input  WIDTH  write data.
REQ-012 rd_en  input  1  read request (FWFT=1: pop/acknowledge).
REQ-013 rdata  output  WIDTH  read data.
REQ-014 full / empty  output  1 each  occupancy == DEPTH / == 0.
REQ-015 almost_full / almost_empty  output  1 each  threshold flags.
REQ-016 count  output  PTR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-017 overflow / underflow  output  1 each  single-cycle error pulses.

Function
REQ-018 Write accepted iff wr_en=1 and full=0 at the edge; wdata stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-019 Read accepted iff rd_en=1 and empty=0 at the edge; rd_ptr increments modulo DEPTH.
REQ-020 count: +1 write only, -1 read only, unchanged for both or neither; full/empty/almost flags decoded from registered count.
REQ-021 Full with simultaneous wr_en and rd_en: read accepted, write rejected, overflow pulses, count becomes DEPTH-1.
REQ-022 Empty with simultaneous wr_en and rd_en: write accepted, read rejected, underflow pulses, count becomes 1.
REQ-023 overflow is 1 for exactly the cycle after a rejected write; underflow likewise after a rejected read; both registered.
REQ-024 FWFT=0: rdata loads mem[rd_ptr] on an accepted read, valid the following cycle, holds value otherwise.
REQ-025 FWFT=1: rdata equals mem[rd_ptr] whenever empty=0 with zero latency; first write visible the cycle after it is written; rdata undefined-but-stable (last head) when empty.
REQ-026 Pointer wrap from DEPTH-1 to 0 is seamless; no data loss or flag glitch at wrap.
REQ-027 clear=1: pointers and count to 0, overflow/underflow 0, wr_en/rd_en ignored that cycle, memory contents untouched, rdata holds.

Reset
REQ-028 rst=0 asynchronously forces: pointers 0, count 0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rdata=0.
REQ-029 Memory array is not reset; reset asserted mid-traffic discards all stored entries.
REQ-030 Operation resumes on the first rising edge after rst deasserts; no transaction accepted while rst=0.

Structure
REQ-031 Shared package fifo_pkg holds FIFO_MODE_STD=0, FIFO_MODE_FWFT=1 and the clog2 helper function.
REQ-032 Storage is sub-module fifo_mem: DEPTH x WIDTH register array, synchronous write, asynchronous read.
REQ-033 Pointer, count, flag and error logic live in param_sync_fifo; illegal parameter values (non-power-of-two DEPTH, thresholds outside 0..DEPTH) stop elaboration.

Verification
REQ-034 WIDTH=8, DEPTH=16, FWFT=0: write 16 words 0x50..0x5F -> full=1 after 16th, count=16, almost_full=1 from count 14.
REQ-035 Full, one extra write 0xAA -> overflow pulses 1 cycle, count stays 16, 0xAA never read back.
REQ-036 Read 16 from full -> rdata 0x50..0x5F in order one cycle after each rd_en, empty=1 at end; 17th read -> underflow pulse.
REQ-037 FWFT=1: single write 0x3C into empty -> rdata=0x3C next cycle without rd_en; rd_en pops, empty=1.
REQ-038 Write 10, read 10, write 12 (wraps ptrs), concurrent rd/wr 20 cycles -> scoreboard order match, count constant.
REQ-039 count=9, clear pulsed with wr_en=1 -> count=0, empty=1; rst asserted mid-write burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode encodings and
// the pointer-width helper used by the FIFO and its interface.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Handshake bundle for param_sync_fifo: write/read
// requests, data and status flags.
interface param_sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) ();

  localparam int CW = clog2(DEPTH) + 1;

  logic             clear;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             rd_en;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, wr_en, wdata, rd_en,
    input  rdata, full, empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  clear, wr_en, wdata, rd_en,
    output rdata, full, empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: register array with synchronous
// write and asynchronous read; never reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO with threshold flags,
// error pulses and standard or fall-through read mode.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = FIFO_MODE_STD
) (
  input  logic clk,
  input  logic rst,
  param_sync_fifo_if.slave bus
);

  localparam int PTR_WIDTH = clog2(DEPTH);
  localparam int CW        = PTR_WIDTH + 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "param_sync_fifo: DEPTH must be a power of two >= 4");
  end
  if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
    $fatal(1, "param_sync_fifo: AF_THRESH out of range");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_ae
    $fatal(1, "param_sync_fifo: AE_THRESH out of range");
  end
  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "param_sync_fifo: WIDTH must be >= 1");
  end

  logic [PTR_WIDTH-1:0] r_wr_ptr;
  logic [PTR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_ovf;
  logic                 r_unf;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic [WIDTH-1:0]     w_mem_rd;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  // clear wins over both requests in the same cycle
  assign w_wr_acc = bus.wr_en & ~w_full & ~bus.clear;
  assign w_rd_acc = bus.rd_en & ~w_empty & ~bus.clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (bus.clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case (1'b1)
        w_wr_acc & ~w_rd_acc: r_count <= r_count + 1'b1;
        w_rd_acc & ~w_wr_acc: r_count <= r_count - 1'b1;
        default: ;
      endcase
      r_ovf <= bus.wr_en & w_full;
      r_unf <= bus.rd_en & w_empty;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rd)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    logic [WIDTH-1:0] r_head;
    // last visible head is held so rdata stays stable once drained
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_head <= '0;
      else if (!w_empty) r_head <= w_mem_rd;
    end
    assign bus.rdata = w_empty ? r_head : w_mem_rd;
  end else begin : g_std
    logic [WIDTH-1:0] r_rdata;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_rdata <= '0;
      else if (w_rd_acc) r_rdata <= w_mem_rd;
    end
    assign bus.rdata = r_rdata;
  end

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= CW'(AF_THRESH));
  assign bus.almost_empty = (r_count <= CW'(AE_THRESH));
  assign bus.count        = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_unf;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo: standard-read
// and fall-through instances driven from one sequence.
module tb_param_sync_fifo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  param_sync_fifo_if #(.WIDTH(8), .DEPTH(16)) bs ();
  param_sync_fifo_if #(.WIDTH(8), .DEPTH(16)) bf ();

  param_sync_fifo #(
    .WIDTH(8), .DEPTH(16), .FWFT(0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bs)
  );

  param_sync_fifo #(
    .WIDTH(8), .DEPTH(16), .FWFT(1)
  ) dut_f (
    .clk(clk), .rst(rst), .bus(bf)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic [7:0] last_rd = 8'h00;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bs.clear = 0; bs.wr_en = 0; bs.rd_en = 0; bs.wdata = 0;
    bf.clear = 0; bf.wr_en = 0; bf.rd_en = 0; bf.wdata = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    step();
    checks++;
    if (bs.count !== 5'd0 || bs.empty !== 1'b1 ||
        bs.almost_empty !== 1'b1 || bs.full !== 1'b0 ||
        bs.almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got cnt=%0d e=%b ae=%b f=%b af=%b exp 0 1 1 0 0",
               bs.count, bs.empty, bs.almost_empty, bs.full, bs.almost_full);
    end
    checks++;
    if (bs.overflow !== 1'b0 || bs.underflow !== 1'b0 ||
        bs.rdata !== 8'h00 || bf.rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_out got ovf=%b unf=%b rd=%h rdf=%h exp 0 0 00 00",
               bs.overflow, bs.underflow, bs.rdata, bf.rdata);
    end
    rst = 1;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      bs.wr_en = 1; bs.wdata = 8'(8'h50 + i);
      q.push_back(8'(8'h50 + i));
      step();
      checks++;
      if (bs.count !== 5'(i + 1) ||
          bs.almost_full !== (i + 1 >= 14) ||
          bs.almost_empty !== (i + 1 <= 2) ||
          bs.full !== (i + 1 == 16)) begin
        errors++;
        $display("FAIL fill_%0d got cnt=%0d af=%b ae=%b f=%b exp cnt=%0d",
                 i, bs.count, bs.almost_full, bs.almost_empty, bs.full, i + 1);
      end
    end
    bs.wr_en = 0;
  endtask

  task automatic test_overflow();
    bs.wr_en = 1; bs.wdata = 8'hAA;
    step();
    bs.wr_en = 0;
    checks++;
    if (bs.overflow !== 1'b1 || bs.count !== 5'd16 || bs.full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pulse got ovf=%b cnt=%0d f=%b exp 1 16 1",
               bs.overflow, bs.count, bs.full);
    end
    step();
    checks++;
    if (bs.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got ovf=%b exp 0", bs.overflow);
    end
  endtask

  task automatic test_drain();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      bs.rd_en = 1;
      step();
      exp = q.pop_front();
      last_rd = exp;
      checks++;
      if (bs.rdata !== exp || bs.count !== 5'(15 - i)) begin
        errors++;
        $display("FAIL drain_%0d got rd=%h cnt=%0d exp rd=%h cnt=%0d",
                 i, bs.rdata, bs.count, exp, 15 - i);
      end
    end
    bs.rd_en = 0;
    checks++;
    if (bs.empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty got %b exp 1", bs.empty);
    end
    bs.rd_en = 1;
    step();
    bs.rd_en = 0;
    checks++;
    if (bs.underflow !== 1'b1 || bs.rdata !== last_rd || bs.count !== 5'd0) begin
      errors++;
      $display("FAIL unf_pulse got unf=%b rd=%h cnt=%0d exp 1 %h 0",
               bs.underflow, bs.rdata, bs.count, last_rd);
    end
    step();
    checks++;
    if (bs.underflow !== 1'b0) begin
      errors++;
      $display("FAIL unf_clear got unf=%b exp 0", bs.underflow);
    end
  endtask

  task automatic test_edges();
    logic [7:0] exp;
    bs.wr_en = 1; bs.rd_en = 1; bs.wdata = 8'h11;
    q.push_back(8'h11);
    step();
    bs.rd_en = 0;
    checks++;
    if (bs.underflow !== 1'b1 || bs.count !== 5'd1) begin
      errors++;
      $display("FAIL empty_wr_rd got unf=%b cnt=%0d exp 1 1",
               bs.underflow, bs.count);
    end
    for (int i = 0; i < 15; i++) begin
      bs.wdata = 8'(8'h20 + i);
      q.push_back(8'(8'h20 + i));
      step();
    end
    bs.rd_en = 1; bs.wdata = 8'h77;
    step();
    bs.wr_en = 0; bs.rd_en = 0;
    exp = q.pop_front();
    last_rd = exp;
    checks++;
    if (bs.overflow !== 1'b1 || bs.count !== 5'd15 || bs.rdata !== exp) begin
      errors++;
      $display("FAIL full_wr_rd got ovf=%b cnt=%0d rd=%h exp 1 15 %h",
               bs.overflow, bs.count, bs.rdata, exp);
    end
    for (int i = 0; i < 15; i++) begin
      bs.rd_en = 1;
      step();
      exp = q.pop_front();
      last_rd = exp;
      checks++;
      if (bs.rdata !== exp) begin
        errors++;
        $display("FAIL edge_drain_%0d got %h exp %h", i, bs.rdata, exp);
      end
    end
    bs.rd_en = 0;
  endtask

  task automatic test_fwft();
    bf.wr_en = 1; bf.wdata = 8'h3C;
    step();
    bf.wr_en = 0;
    checks++;
    if (bf.rdata !== 8'h3C || bf.empty !== 1'b0) begin
      errors++;
      $display("FAIL fwft_show got rd=%h e=%b exp 3c 0", bf.rdata, bf.empty);
    end
    step();
    checks++;
    if (bf.rdata !== 8'h3C) begin
      errors++;
      $display("FAIL fwft_hold got %h exp 3c", bf.rdata);
    end
    bf.rd_en = 1;
    step();
    bf.rd_en = 0;
    checks++;
    if (bf.empty !== 1'b1 || bf.rdata !== 8'h3C) begin
      errors++;
      $display("FAIL fwft_pop got e=%b rd=%h exp 1 3c", bf.empty, bf.rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    logic [7:0] d;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom_range(0, 255));
      bs.wr_en = 1; bs.wdata = d; q.push_back(d);
      step();
    end
    bs.wr_en = 0;
    for (int i = 0; i < 10; i++) begin
      bs.rd_en = 1;
      step();
      exp = q.pop_front(); last_rd = exp;
      checks++;
      if (bs.rdata !== exp) begin
        errors++;
        $display("FAIL b2b_rd_%0d got %h exp %h", i, bs.rdata, exp);
      end
    end
    bs.rd_en = 0;
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      bs.wr_en = 1; bs.wdata = d; q.push_back(d);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom_range(0, 255));
      bs.wr_en = 1; bs.rd_en = 1; bs.wdata = d;
      exp = q.pop_front(); last_rd = exp;
      q.push_back(d);
      step();
      checks++;
      if (bs.rdata !== exp || bs.count !== 5'd12) begin
        errors++;
        $display("FAIL b2b_cc_%0d got rd=%h cnt=%0d exp %h 12",
                 i, bs.rdata, bs.count, exp);
      end
    end
    bs.wr_en = 0;
    for (int i = 0; i < 12; i++) begin
      bs.rd_en = 1;
      step();
      exp = q.pop_front(); last_rd = exp;
      checks++;
      if (bs.rdata !== exp) begin
        errors++;
        $display("FAIL b2b_tail_%0d got %h exp %h", i, bs.rdata, exp);
      end
    end
    bs.rd_en = 0;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 9; i++) begin
      bs.wr_en = 1; bs.wdata = 8'(8'hC0 + i);
      step();
    end
    checks++;
    if (bs.count !== 5'd9) begin
      errors++;
      $display("FAIL clr_pre got %0d exp 9", bs.count);
    end
    bs.clear = 1; bs.wr_en = 1; bs.wdata = 8'hEE;
    step();
    bs.clear = 0; bs.wr_en = 0;
    checks++;
    if (bs.count !== 5'd0 || bs.empty !== 1'b1 || bs.rdata !== last_rd) begin
      errors++;
      $display("FAIL clr_post got cnt=%0d e=%b rd=%h exp 0 1 %h",
               bs.count, bs.empty, bs.rdata, last_rd);
    end
    bs.wr_en = 1; bs.wdata = 8'h42;
    step();
    bs.wr_en = 0; bs.rd_en = 1;
    step();
    bs.rd_en = 0;
    last_rd = 8'h42;
    checks++;
    if (bs.rdata !== 8'h42 || bs.empty !== 1'b1) begin
      errors++;
      $display("FAIL clr_resume got rd=%h e=%b exp 42 1", bs.rdata, bs.empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      bs.wr_en = 1; bs.wdata = 8'(8'h80 + i);
      bf.wr_en = 1; bf.wdata = 8'(8'h90 + i);
      step();
    end
    bs.rd_en = 1;
    step();
    #2;
    rst = 0;
    #1;
    checks++;
    if (bs.count !== 5'd0 || bs.empty !== 1'b1 || bs.full !== 1'b0 ||
        bs.rdata !== 8'h00 || bs.overflow !== 1'b0 ||
        bs.almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid got cnt=%0d e=%b f=%b rd=%h ovf=%b ae=%b",
               bs.count, bs.empty, bs.full, bs.rdata, bs.overflow,
               bs.almost_empty);
    end
    checks++;
    if (bf.count !== 5'd0 || bf.rdata !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_f got cnt=%0d rd=%h exp 0 00", bf.count, bf.rdata);
    end
    step();
    checks++;
    if (bs.count !== 5'd0 || bf.empty !== 1'b1) begin
      errors++;
      $display("FAIL rst_hold got cnt=%0d ef=%b exp 0 1", bs.count, bf.empty);
    end
    idle();
    rst = 1;
    bs.wr_en = 1; bs.wdata = 8'h99;
    step();
    bs.wr_en = 0; bs.rd_en = 1;
    step();
    bs.rd_en = 0;
    checks++;
    if (bs.rdata !== 8'h99 || bs.count !== 5'd0) begin
      errors++;
      $display("FAIL rst_resume got rd=%h cnt=%0d exp 99 0", bs.rdata, bs.count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_edges();
    test_fwft();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
